// File: rtl/delay_pkg.sv
// Shared definitions for the delay/tick timer family: FSM states, clog2 helper
// and standard 50 MHz period constants.
package delay_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned CLK50_HZ     = 50_000_000;
    localparam int unsigned PERIOD_250MS = CLK50_HZ / 4;
    localparam int unsigned PERIOD_500MS = CLK50_HZ / 2;
    localparam int unsigned PERIOD_1S    = CLK50_HZ;

    // Bits needed to hold values 0..value-1; never less than one.
    function automatic int clog2(input longint unsigned value);
        int r;
        r = 0;
        while ((64'd1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/delay_tick_timer_if.sv
// Control/status bundle of delay_tick_timer; tick_cnt exists only when
// DELAY_TICK_CNT_EN is defined.
interface delay_tick_timer_if #(
    parameter int CNT_W = 24
);
    logic             enable;
    logic             load;
    logic [CNT_W-1:0] period_in;
    logic             oneshot;
    logic             start;
    logic             stop;
    logic             tick;
    logic             Q;
    logic             busy;
    logic             done;
`ifdef DELAY_TICK_CNT_EN
    logic [15:0]      tick_cnt;
`endif

    modport master (
`ifdef DELAY_TICK_CNT_EN
        input  tick_cnt,
`endif
        output enable, load, period_in, oneshot, start, stop,
        input  tick, Q, busy, done
    );

    modport slave (
`ifdef DELAY_TICK_CNT_EN
        output tick_cnt,
`endif
        input  enable, load, period_in, oneshot, start, stop,
        output tick, Q, busy, done
    );
endinterface

// File: rtl/delay_tick_timer_downcounter.sv
// Loadable down-counter with clear and decrement enable; tc flags a zero count.
module tick_downcounter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         tc
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == '0);
endmodule

// File: rtl/delay_tick_timer.sv
// Programmable tick/square-wave timer with one-shot and periodic modes.
// Optional 16-bit tick counter output under DELAY_TICK_CNT_EN.
module delay_tick_timer
    import delay_pkg::*;
#(
    parameter int unsigned MAX_PERIOD     = 12_500_000,
    parameter int unsigned DEFAULT_PERIOD = 12_500_000
) (
    input  logic               CLOCK_50,
    input  logic               aclr,
    delay_tick_timer_if.slave  bus
);
    localparam int CNT_W = clog2(longint'(MAX_PERIOD) + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             out_q, out_d;

    logic [CNT_W-1:0] clamped;
    logic [CNT_W-1:0] eff_period;
    logic             cnt_clr, cnt_load, cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_tc;

    always_comb begin
        if (bus.period_in == '0) begin
            clamped = CNT_W'(1);
        end else if (bus.period_in > CNT_W'(MAX_PERIOD)) begin
            clamped = CNT_W'(MAX_PERIOD);
        end else begin
            clamped = bus.period_in;
        end
    end

    // A start coinciding with load must see the freshly written period.
    assign eff_period = bus.load ? clamped : period_q;
    assign period_d   = bus.load ? clamped : period_q;

    // Priority: stop > start/retrigger > terminal count > decrement.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        tick_d       = 1'b0;
        out_d        = out_q;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = eff_period - CNT_W'(1);
        if (bus.stop) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else if (bus.start) begin
            state_d  = RUN;
            mode_d   = bus.oneshot;
            cnt_load = 1'b1;
        end else if ((state_q == RUN) && bus.enable) begin
            if (cnt_tc) begin
                tick_d = 1'b1;
                out_d  = ~out_q;
                if (mode_q) begin
                    state_d = DONE;
                end else begin
                    cnt_load     = 1'b1;
                    cnt_load_val = period_q - CNT_W'(1);
                end
            end else begin
                cnt_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (aclr) begin
            state_q  <= IDLE;
            period_q <= CNT_W'(DEFAULT_PERIOD);
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            out_q    <= out_d;
        end
    end

    tick_downcounter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (CLOCK_50),
        .srst     (aclr),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .tc       (cnt_tc)
    );

`ifdef DELAY_TICK_CNT_EN
    logic [15:0] tick_cnt_q, tick_cnt_d;

    // Retrigger from RUN keeps the running total.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (!bus.stop && bus.start && (state_q != RUN)) begin
            tick_cnt_d = '0;
        end else if (tick_d) begin
            tick_cnt_d = tick_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (aclr) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign bus.tick_cnt = tick_cnt_q;
`endif

    assign bus.tick = tick_q;
    assign bus.Q    = out_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);

    logic unused_ok;
    assign unused_ok = ^cnt_value;
endmodule

// File: tb/tb_delay_tick_timer.sv
// Directed self-checking bench for delay_tick_timer (MAX_PERIOD=16, DEFAULT_PERIOD=4).
module tb_delay_tick_timer;
    import delay_pkg::*;

    localparam int CNT_W = clog2(17);

    logic clk  = 1'b0;
    logic aclr = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic q_exp  = 1'b0;

    always #5 clk = ~clk;

    delay_tick_timer_if #(.CNT_W(CNT_W)) bus ();

    delay_tick_timer #(
        .MAX_PERIOD     (16),
        .DEFAULT_PERIOD (4)
    ) dut (
        .CLOCK_50 (clk),
        .aclr     (aclr),
        .bus      (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; expect tick as given and Q to follow the tick history.
    task automatic step_chk(input string tag, input logic exp_tick);
        step();
        if (exp_tick) q_exp = ~q_exp;
        chk({tag, "_tick"}, {31'd0, bus.tick}, {31'd0, exp_tick});
        chk({tag, "_q"}, {31'd0, bus.Q}, {31'd0, q_exp});
        $display("%s: tick=%0b Q=%0b busy=%0b done=%0b", tag, bus.tick, bus.Q, bus.busy, bus.done);
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) step_chk(tag, 1'b0);
    endtask

    task automatic pulse_start(input logic os, input logic do_load, input logic [CNT_W-1:0] per);
        bus.start = 1'b1; bus.oneshot = os; bus.load = do_load; bus.period_in = per;
        step();
        bus.start = 1'b0; bus.load = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b0; bus.load = 1'b0; bus.period_in = '0;
        bus.oneshot = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;

        // 1. reset, periodic default period 4
        aclr = 1'b1; step(); step(); aclr = 1'b0;
        chk("rst_tick", {31'd0, bus.tick}, 32'd0);
        chk("rst_q",    {31'd0, bus.Q},    32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        bus.enable = 1'b1;
        pulse_start(1'b0, 1'b0, '0);
        chk("t1_busy", {31'd0, bus.busy}, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            step_chk("t1", (k % 4) == 0);
            chk("t1_busy_run", {31'd0, bus.busy}, 32'd1);
        end
`ifdef DELAY_TICK_CNT_EN
        chk("t1_tick_cnt", {16'd0, bus.tick_cnt}, 32'd3);
`endif

        // 2. period 0 clamps to 1, then 20 clamps to 16
        bus.load = 1'b1; bus.period_in = '0;
        step_chk("t2_load0", 1'b0);
        bus.load = 1'b0;
        bus.start = 1'b1;
        step_chk("t2_restart", 1'b0);
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) step_chk("t2_every", 1'b1);
        bus.load = 1'b1; bus.period_in = 5'd20;
        step_chk("t2_load20", 1'b1);
        bus.load = 1'b0;
        step_chk("t2_last1", 1'b1);
        quiet("t2_gap16", 15);
        step_chk("t2_tick16", 1'b1);
        bus.stop = 1'b1;
        step_chk("t2_stop", 1'b0);
        bus.stop = 1'b0;
        chk("t2_stop_busy", {31'd0, bus.busy}, 32'd0);

        // 3. one-shot period 5, then restart from DONE
        pulse_start(1'b1, 1'b1, 5'd5);
        quiet("t3_wait", 4);
        step_chk("t3_tick", 1'b1);
        chk("t3_done", {31'd0, bus.done}, 32'd1);
        chk("t3_busy", {31'd0, bus.busy}, 32'd0);
        step_chk("t3_hold", 1'b0);
        chk("t3_done_hold", {31'd0, bus.done}, 32'd1);
        pulse_start(1'b1, 1'b0, '0);
        chk("t3_done_clr", {31'd0, bus.done}, 32'd0);
        chk("t3_busy2", {31'd0, bus.busy}, 32'd1);
        quiet("t3_wait2", 4);
        step_chk("t3_tick2", 1'b1);
        chk("t3_done2", {31'd0, bus.done}, 32'd1);

        // 4. period 6 with 3-cycle enable gap, then mid-count load of 2
        pulse_start(1'b0, 1'b1, 5'd6);
        quiet("t4_pre", 2);
        bus.enable = 1'b0;
        quiet("t4_frozen", 3);
        chk("t4_busy_frozen", {31'd0, bus.busy}, 32'd1);
        bus.enable = 1'b1;
        quiet("t4_post", 3);
        step_chk("t4_tick", 1'b1);
        bus.load = 1'b1; bus.period_in = 5'd2;
        step_chk("t4_load2", 1'b0);
        bus.load = 1'b0;
        quiet("t4_old6", 4);
        step_chk("t4_tick6", 1'b1);
        step_chk("t4_gap2", 1'b0);
        step_chk("t4_tick2", 1'b1);

        // 5. start+stop at terminal count; retrigger at count 1
        step_chk("t5_pre", 1'b0);
        bus.start = 1'b1; bus.stop = 1'b1;
        step_chk("t5_startstop", 1'b0);
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("t5_idle", {31'd0, bus.busy}, 32'd0);
        pulse_start(1'b0, 1'b1, 5'd4);
        quiet("t5_count", 2);
        bus.start = 1'b1;
        step_chk("t5_retrig", 1'b0);
        bus.start = 1'b0;
        quiet("t5_wait", 3);
        step_chk("t5_tick", 1'b1);

        // 6. aclr mid-RUN with Q high
        chk("t6_q_before", {31'd0, bus.Q}, 32'd1);
        step_chk("t6_run", 1'b0);
        aclr = 1'b1;
        step();
        aclr = 1'b0;
        q_exp = 1'b0;
        chk("t6_tick", {31'd0, bus.tick}, 32'd0);
        chk("t6_q",    {31'd0, bus.Q},    32'd0);
        chk("t6_busy", {31'd0, bus.busy}, 32'd0);
`ifdef DELAY_TICK_CNT_EN
        chk("t6_tick_cnt", {16'd0, bus.tick_cnt}, 32'd0);
`endif
        pulse_start(1'b0, 1'b0, '0);
        quiet("t6_wait", 3);
        step_chk("t6_tick_def", 1'b1);
`ifdef DELAY_TICK_CNT_EN
        chk("t6_tick_cnt1", {16'd0, bus.tick_cnt}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
